// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: sequential instruction fetch over req/gnt/rvalid with a
// DEPTH-entry prefetch FIFO presenting {pc, instr} to decode.
module fetch_prefetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               im_req,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic               im_gnt,
    input  logic               im_rvalid,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc, req_pc;
    logic               outstanding, drop;
    logic [PW:0]        count;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [ADDR_W-1:0]  pc_mem [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic               grant, push, pop;

    // Issuing only while nothing is outstanding and count < DEPTH keeps a slot for the response.
    assign im_req   = rst_n & ~outstanding & ~halt & ~redirect_valid & (count < (PW+1)'(DEPTH));
    assign im_addr  = fetch_pc;
    assign grant    = im_req & im_gnt;
    assign push     = im_rvalid & outstanding & ~drop & ~redirect_valid;
    assign pop      = id_valid & id_ready & ~redirect_valid;
    assign id_valid = count != '0;
    assign id_pc    = pc_mem[rd_ptr];
    assign id_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= '0;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            if (grant) begin
                req_pc      <= fetch_pc;
                outstanding <= 1'b1;
            end
            if (im_rvalid & outstanding) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end else if (redirect_valid & outstanding) begin
                drop <= 1'b1;
            end
            fetch_pc <= redirect_valid ? redirect_pc : grant ? fetch_pc + 1'b1 : fetch_pc;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]    <= req_pc;
                    instr_mem[wr_ptr] <= im_rdata;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end
endmodule
